// File: rtl/axi4_tcm_responder.sv
// AXI4 burst responder backed by a single-port 32-bit word RAM.
// Serves one write or read burst at a time; FIXED bursts hold the address,
// all other burst types increment the word address with wrap at the RAM size.
// Optional build macro: AXI_TCM_RESP_OOR_ERR_EN (start-address range check
// against BASE_ADDR; out-of-range bursts suppress writes and return SLVERR).
module axi4_tcm_responder #(
    parameter int unsigned MEM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        axi_awvalid_i,
    input  logic [31:0] axi_awaddr_i,
    input  logic [3:0]  axi_awid_i,
    input  logic [7:0]  axi_awlen_i,
    input  logic [1:0]  axi_awburst_i,
    output logic        axi_awready_o,
    input  logic        axi_wvalid_i,
    input  logic [31:0] axi_wdata_i,
    input  logic [3:0]  axi_wstrb_i,
    input  logic        axi_wlast_i,
    output logic        axi_wready_o,
    output logic        axi_bvalid_o,
    output logic [1:0]  axi_bresp_o,
    output logic [3:0]  axi_bid_o,
    input  logic        axi_bready_i,
    input  logic        axi_arvalid_i,
    input  logic [31:0] axi_araddr_i,
    input  logic [3:0]  axi_arid_i,
    input  logic [7:0]  axi_arlen_i,
    input  logic [1:0]  axi_arburst_i,
    output logic        axi_arready_o,
    output logic        axi_rvalid_o,
    output logic [31:0] axi_rdata_o,
    output logic [1:0]  axi_rresp_o,
    output logic [3:0]  axi_rid_o,
    output logic        axi_rlast_o,
    input  logic        axi_rready_i
);

    typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_t;

    state_t              state_q, state_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [3:0]          id_q, id_d;
    logic [7:0]          len_q, len_d;
    logic [1:0]          burst_q, burst_d;
    // 9 bits so a 256-beat read can count "all issued" without wrapping
    logic [8:0]          cnt_q, cnt_d;
    // 0: read wins a tie, 1: write wins a tie
    logic                prio_q, prio_d;
    logic                err_q, err_d;
    logic                oor_q, oor_d;
    logic                rvalid_q, rvalid_d;
    logic                rlast_q, rlast_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [31:0]         mem [0:(1<<MEM_AW)-1];

    logic                grant_w, grant_r;
    logic [31:0]         start_addr;
    logic                start_oor;
    logic [MEM_AW-1:0]   addr_next;
    logic                last_beat, issue_left;
    logic                ram_we, ram_re;

    assign grant_w    = axi_awvalid_i && (!axi_arvalid_i || prio_q);
    assign grant_r    = axi_arvalid_i && (!axi_awvalid_i || !prio_q);
    assign start_addr = grant_w ? axi_awaddr_i : axi_araddr_i;

`ifdef AXI_TCM_RESP_OOR_ERR_EN
    logic [32:0] start_off;
    logic        unused_off;
    assign start_off  = {1'b0, start_addr} - {1'b0, BASE_ADDR};
    assign start_oor  = start_off[32] || (start_off[31:MEM_AW+2] != '0);
    assign unused_off = ^start_off[MEM_AW+1:0];
`else
    // Upper address bits alias onto the RAM; no window check.
    logic unused_addr;
    assign start_oor   = 1'b0;
    assign unused_addr = ^{start_addr[31:MEM_AW+2], start_addr[1:0], BASE_ADDR};
`endif

    assign addr_next  = (burst_q == 2'b00) ? addr_q : addr_q + {{(MEM_AW-1){1'b0}}, 1'b1};
    assign last_beat  = (cnt_q[7:0] == len_q);
    assign issue_left = (cnt_q <= {1'b0, len_q});
    assign ram_we     = (state_q == S_WDATA) && axi_wvalid_i && !oor_q;
    // Read only when the output slot is free or being drained this cycle
    assign ram_re     = (state_q == S_RDATA) && (!rvalid_q || axi_rready_i) && issue_left;

    // Next-state, address/beat bookkeeping and read pipeline
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        id_d     = id_q;
        len_d    = len_q;
        burst_d  = burst_q;
        cnt_d    = cnt_q;
        prio_d   = prio_q;
        err_d    = err_q;
        oor_d    = oor_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_w || grant_r) begin
                    addr_d  = start_addr[MEM_AW+1:2];
                    id_d    = grant_w ? axi_awid_i    : axi_arid_i;
                    len_d   = grant_w ? axi_awlen_i   : axi_arlen_i;
                    burst_d = grant_w ? axi_awburst_i : axi_arburst_i;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    oor_d   = start_oor;
                    prio_d  = !prio_q;
                    state_d = grant_w ? S_WDATA : S_RDATA;
                end
            end
            S_WDATA: begin
                if (axi_wvalid_i) begin
                    addr_d = addr_next;
                    cnt_d  = cnt_q + 9'd1;
                    if (axi_wlast_i != last_beat) err_d = 1'b1;
                    if (last_beat) state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                if (axi_bready_i) state_d = S_IDLE;
            end
            S_RDATA: begin
                if (ram_re) begin
                    rvalid_d = 1'b1;
                    rlast_d  = last_beat;
                    rdata_d  = oor_q ? 32'h0 : mem[addr_q];
                    addr_d   = addr_next;
                    cnt_d    = cnt_q + 9'd1;
                end else if (rvalid_q && axi_rready_i) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                end
                if (rvalid_q && axi_rready_i && rlast_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and read-output registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            id_q     <= '0;
            len_q    <= '0;
            burst_q  <= '0;
            cnt_q    <= '0;
            prio_q   <= 1'b0;
            err_q    <= 1'b0;
            oor_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            id_q     <= id_d;
            len_q    <= len_d;
            burst_q  <= burst_d;
            cnt_q    <= cnt_d;
            prio_q   <= prio_d;
            err_q    <= err_d;
            oor_q    <= oor_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            rdata_q  <= rdata_d;
        end
    end

    // Byte-enabled RAM write; contents survive reset
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (axi_wstrb_i[b]) mem[addr_q][8*b +: 8] <= axi_wdata_i[8*b +: 8];
            end
        end
    end

    assign axi_awready_o = (state_q == S_IDLE) && grant_w;
    assign axi_arready_o = (state_q == S_IDLE) && grant_r;
    assign axi_wready_o  = (state_q == S_WDATA);
    assign axi_bvalid_o  = (state_q == S_WRESP);
    assign axi_bresp_o   = (axi_bvalid_o && (err_q || oor_q)) ? 2'b10 : 2'b00;
    assign axi_bid_o     = axi_bvalid_o ? id_q : 4'h0;
    assign axi_rvalid_o  = rvalid_q;
    assign axi_rdata_o   = rdata_q;
    assign axi_rresp_o   = (rvalid_q && oor_q) ? 2'b10 : 2'b00;
    assign axi_rid_o     = rvalid_q ? id_q : 4'h0;
    assign axi_rlast_o   = rlast_q;

endmodule

// File: tb/tb_axi4_tcm_responder.sv
// Directed bench for axi4_tcm_responder with a reference memory model and
// response scoreboards.
module tb_axi4_tcm_responder;
    localparam int MEM_AW = 10;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        axi_awvalid_i = 1'b0;
    logic [31:0] axi_awaddr_i = '0;
    logic [3:0]  axi_awid_i = '0;
    logic [7:0]  axi_awlen_i = '0;
    logic [1:0]  axi_awburst_i = '0;
    logic        axi_awready_o;
    logic        axi_wvalid_i = 1'b0;
    logic [31:0] axi_wdata_i = '0;
    logic [3:0]  axi_wstrb_i = '0;
    logic        axi_wlast_i = 1'b0;
    logic        axi_wready_o;
    logic        axi_bvalid_o;
    logic [1:0]  axi_bresp_o;
    logic [3:0]  axi_bid_o;
    logic        axi_bready_i = 1'b0;
    logic        axi_arvalid_i = 1'b0;
    logic [31:0] axi_araddr_i = '0;
    logic [3:0]  axi_arid_i = '0;
    logic [7:0]  axi_arlen_i = '0;
    logic [1:0]  axi_arburst_i = '0;
    logic        axi_arready_o;
    logic        axi_rvalid_o;
    logic [31:0] axi_rdata_o;
    logic [1:0]  axi_rresp_o;
    logic [3:0]  axi_rid_o;
    logic        axi_rlast_o;
    logic        axi_rready_i = 1'b0;

    always #5 clk_i = ~clk_i;

    axi4_tcm_responder #(.MEM_AW(MEM_AW), .BASE_ADDR(32'h0000_0000)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .axi_awvalid_i(axi_awvalid_i), .axi_awaddr_i(axi_awaddr_i), .axi_awid_i(axi_awid_i),
        .axi_awlen_i(axi_awlen_i), .axi_awburst_i(axi_awburst_i), .axi_awready_o(axi_awready_o),
        .axi_wvalid_i(axi_wvalid_i), .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i),
        .axi_wlast_i(axi_wlast_i), .axi_wready_o(axi_wready_o),
        .axi_bvalid_o(axi_bvalid_o), .axi_bresp_o(axi_bresp_o), .axi_bid_o(axi_bid_o),
        .axi_bready_i(axi_bready_i),
        .axi_arvalid_i(axi_arvalid_i), .axi_araddr_i(axi_araddr_i), .axi_arid_i(axi_arid_i),
        .axi_arlen_i(axi_arlen_i), .axi_arburst_i(axi_arburst_i), .axi_arready_o(axi_arready_o),
        .axi_rvalid_o(axi_rvalid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
        .axi_rid_o(axi_rid_o), .axi_rlast_o(axi_rlast_o), .axi_rready_i(axi_rready_i)
    );

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;
    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    logic [31:0] mem_m [0:(1<<MEM_AW)-1];
    r_exp_t      exp_r[$];
    b_exp_t      exp_b[$];
    logic [31:0] wd_q[$];
    logic [3:0]  ws_q[$];
    logic        wl_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic oor_f(input logic [31:0] a);
`ifdef AXI_TCM_RESP_OOR_ERR_EN
        return (a >= (32'd4 << MEM_AW));
`else
        return (a != a);
`endif
    endfunction

    // Queue up a write burst: standard wlast, same strobe on every beat
    task automatic load_w(input logic [31:0] base, input logic [31:0] step, input int len, input logic [3:0] strb);
        for (int i = 0; i <= len; i++) begin
            wd_q.push_back(base + step * 32'(i));
            ws_q.push_back(strb);
            wl_q.push_back(i == len);
        end
    endtask

    task automatic aw_phase(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        axi_awaddr_i = a; axi_awid_i = id; axi_awlen_i = len; axi_awburst_i = burst;
        axi_awvalid_i = 1'b1;
        #1;
        while (!axi_awready_o && n < 100) begin @(negedge clk_i); #1; n++; end
        if (n >= 100) chk("aw_timeout", {31'b0, axi_awready_o}, 32'd1);
        @(posedge clk_i); @(negedge clk_i);
        axi_awvalid_i = 1'b0;
    endtask

    task automatic ar_phase(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        axi_araddr_i = a; axi_arid_i = id; axi_arlen_i = len; axi_arburst_i = burst;
        axi_arvalid_i = 1'b1;
        #1;
        while (!axi_arready_o && n < 100) begin @(negedge clk_i); #1; n++; end
        if (n >= 100) chk("ar_timeout", {31'b0, axi_arready_o}, 32'd1);
        @(posedge clk_i); @(negedge clk_i);
        axi_arvalid_i = 1'b0;
    endtask

    task automatic w_phase(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input logic [1:0] burst);
        logic [MEM_AW-1:0] word;
        logic oor, err;
        logic [31:0] d; logic [3:0] s; logic l;
        b_exp_t e;
        int n = 0;
        word = a[MEM_AW+1:2]; oor = oor_f(a); err = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            d = wd_q.pop_front(); s = ws_q.pop_front(); l = wl_q.pop_front();
            axi_wvalid_i = 1'b1; axi_wdata_i = d; axi_wstrb_i = s; axi_wlast_i = l;
            #1;
            if (i == 0) chk("wready", {31'b0, axi_wready_o}, 32'd1);
            @(posedge clk_i);
            if (!oor) for (int b = 0; b < 4; b++) if (s[b]) mem_m[word][8*b +: 8] = d[8*b +: 8];
            if (l != (i == int'(len))) err = 1'b1;
            if (burst != 2'b00) word = word + 1'b1;
            @(negedge clk_i);
        end
        axi_wvalid_i = 1'b0; axi_wlast_i = 1'b0;
        exp_b.push_back('{id: id, resp: (err || oor) ? 2'b10 : 2'b00});
        #1;
        while (!axi_bvalid_o && n < 100) begin @(negedge clk_i); #1; n++; end
        chk("bvalid", {31'b0, axi_bvalid_o}, 32'd1);
        @(negedge clk_i); #1;
        chk("bvalid_hold", {31'b0, axi_bvalid_o}, 32'd1);
        axi_bready_i = 1'b1;
        e = exp_b.pop_front();
        chk("bid", {28'b0, axi_bid_o}, {28'b0, e.id});
        chk("bresp", {30'b0, axi_bresp_o}, {30'b0, e.resp});
        @(posedge clk_i); @(negedge clk_i);
        axi_bready_i = 1'b0;
        #1;
        chk("bvalid_clear", {31'b0, axi_bvalid_o}, 32'd0);
    endtask

    // mode 0: rready held high; mode 1: rready pattern 1,0,0,1,0,0...
    task automatic r_phase(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input int mode, input bit chk_lat);
        logic [MEM_AW-1:0] word;
        logic oor, stalled;
        logic [31:0] held;
        r_exp_t e;
        int got = 0, k = 0;
        word = a[MEM_AW+1:2]; oor = oor_f(a);
        for (int i = 0; i <= int'(len); i++) begin
            exp_r.push_back('{data: oor ? 32'h0 : mem_m[word], id: id,
                              resp: oor ? 2'b10 : 2'b00, last: (i == int'(len))});
            if (burst != 2'b00) word = word + 1'b1;
        end
        stalled = 1'b0; held = '0;
        while (got <= int'(len) && k < 3000) begin
            axi_rready_i = (mode == 0) ? 1'b1 : (k % 3 == 0);
            #1;
            if (chk_lat && k <= 1) chk("r_latency", {31'b0, axi_rvalid_o}, (k == 1) ? 32'd1 : 32'd0);
            if (stalled) begin
                chk("r_hold_valid", {31'b0, axi_rvalid_o}, 32'd1);
                chk("r_hold_data", axi_rdata_o, held);
            end
            if (axi_rvalid_o && axi_rready_i) begin
                e = exp_r.pop_front();
                chk("rdata", axi_rdata_o, e.data);
                chk("rid", {28'b0, axi_rid_o}, {28'b0, e.id});
                chk("rresp", {30'b0, axi_rresp_o}, {30'b0, e.resp});
                chk("rlast", {31'b0, axi_rlast_o}, {31'b0, e.last});
                got++;
            end
            stalled = axi_rvalid_o && !axi_rready_i;
            held = axi_rdata_o;
            @(posedge clk_i); @(negedge clk_i);
            k++;
        end
        if (got <= int'(len)) chk("r_beats", 32'(got), 32'(int'(len) + 1));
        axi_rready_i = 1'b0;
        #1;
        chk("r_done_idle", {31'b0, axi_rvalid_o}, 32'd0);
        chk("r_sb_empty", 32'(exp_r.size()), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_awready"}, {31'b0, axi_awready_o}, 32'd0);
        chk({tag, "_arready"}, {31'b0, axi_arready_o}, 32'd0);
        chk({tag, "_wready"},  {31'b0, axi_wready_o}, 32'd0);
        chk({tag, "_bvalid"},  {31'b0, axi_bvalid_o}, 32'd0);
        chk({tag, "_bresp"},   {30'b0, axi_bresp_o}, 32'd0);
        chk({tag, "_bid"},     {28'b0, axi_bid_o}, 32'd0);
        chk({tag, "_rvalid"},  {31'b0, axi_rvalid_o}, 32'd0);
        chk({tag, "_rdata"},   axi_rdata_o, 32'd0);
        chk({tag, "_rresp"},   {30'b0, axi_rresp_o}, 32'd0);
        chk({tag, "_rid"},     {28'b0, axi_rid_o}, 32'd0);
        chk({tag, "_rlast"},   {31'b0, axi_rlast_o}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < (1 << MEM_AW); i++) mem_m[i] = 'x;

        // Reset values
        repeat (3) @(negedge clk_i);
        #1;
        check_outputs_zero("reset");
        rst_i = 1'b1;
        @(negedge clk_i);

        // INCR write then read back
        load_w(32'hA0, 32'h1, 3, 4'hF);
        aw_phase(32'h10, 4'd3, 8'd3, 2'b01);
        w_phase(32'h10, 4'd3, 8'd3, 2'b01);
        ar_phase(32'h10, 4'd9, 8'd3, 2'b01);
        r_phase(32'h10, 4'd9, 8'd3, 2'b01, 0, 1'b1);

        // Strobes with FIXED burst
        wd_q.push_back(32'hFFFF_FFFF); ws_q.push_back(4'hF);     wl_q.push_back(1'b0);
        wd_q.push_back(32'h1234_5678); ws_q.push_back(4'b0101);  wl_q.push_back(1'b1);
        aw_phase(32'h20, 4'd5, 8'd1, 2'b00);
        w_phase(32'h20, 4'd5, 8'd1, 2'b00);
        ar_phase(32'h20, 4'd6, 8'd1, 2'b00);
        r_phase(32'h20, 4'd6, 8'd1, 2'b00, 0, 1'b0);
        chk("strobe_model", mem_m[8], 32'hFF34_FF78);

        // Backpressure on an 8-beat read
        load_w(32'hC000_0000, 32'h0101, 7, 4'hF);
        aw_phase(32'h40, 4'd1, 8'd7, 2'b01);
        w_phase(32'h40, 4'd1, 8'd7, 2'b01);
        ar_phase(32'h40, 4'd2, 8'd7, 2'b01);
        r_phase(32'h40, 4'd2, 8'd7, 2'b01, 1, 1'b0);

        // Early wlast: all four beats still accepted, SLVERR
        for (int i = 0; i < 4; i++) begin
            wd_q.push_back(32'hE000_0000 + 32'(i)); ws_q.push_back(4'hF); wl_q.push_back(i == 1);
        end
        aw_phase(32'h80, 4'd7, 8'd3, 2'b10);
        w_phase(32'h80, 4'd7, 8'd3, 2'b10);
        ar_phase(32'h80, 4'd7, 8'd3, 2'b01);
        r_phase(32'h80, 4'd7, 8'd3, 2'b01, 0, 1'b0);

        // Address wrap at the top of the RAM
        load_w(32'h7700_0000, 32'h1, 1, 4'hF);
        aw_phase(32'hFFC, 4'd4, 8'd1, 2'b01);
        w_phase(32'hFFC, 4'd4, 8'd1, 2'b01);
        ar_phase(32'hFFC, 4'd4, 8'd1, 2'b01);
        r_phase(32'hFFC, 4'd4, 8'd1, 2'b01, 0, 1'b0);

        // 256-beat bursts
        load_w(32'h0300_0000, 32'h0001_0003, 255, 4'hF);
        aw_phase(32'h0, 4'd10, 8'd255, 2'b01);
        w_phase(32'h0, 4'd10, 8'd255, 2'b01);
        ar_phase(32'h0, 4'd11, 8'd255, 2'b01);
        r_phase(32'h0, 4'd11, 8'd255, 2'b01, 0, 1'b0);

        // Above the window: aliases in the default build, SLVERR when checked
        load_w(32'hDEAD_0000, 32'h1, 0, 4'hF);
        aw_phase(32'h1000, 4'd12, 8'd0, 2'b01);
        w_phase(32'h1000, 4'd12, 8'd0, 2'b01);
        ar_phase(32'h1000, 4'd13, 8'd0, 2'b01);
        r_phase(32'h1000, 4'd13, 8'd0, 2'b01, 0, 1'b0);
        ar_phase(32'h1010, 4'd13, 8'd1, 2'b01);
        r_phase(32'h1010, 4'd13, 8'd1, 2'b01, 0, 1'b0);
        ar_phase(32'h0, 4'd14, 8'd0, 2'b01);
        r_phase(32'h0, 4'd14, 8'd0, 2'b01, 0, 1'b0);

        // Reset in the middle of a read burst
        ar_phase(32'h40, 4'd15, 8'd7, 2'b01);
        n = 0;
        #1;
        while (!axi_rvalid_o && n < 20) begin @(negedge clk_i); #1; n++; end
        chk("mid_rvalid", {31'b0, axi_rvalid_o}, 32'd1);
        rst_i = 1'b0;
        #1;
        check_outputs_zero("midreset");
        @(negedge clk_i);
        rst_i = 1'b1;
        ar_phase(32'h10, 4'd8, 8'd0, 2'b01);
        r_phase(32'h10, 4'd8, 8'd0, 2'b01, 0, 1'b0);

        // Round-robin on simultaneous AW/AR, fresh from reset
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        axi_awaddr_i = 32'h100; axi_awid_i = 4'd1; axi_awlen_i = 8'd0; axi_awburst_i = 2'b01;
        axi_araddr_i = 32'h10;  axi_arid_i = 4'd2; axi_arlen_i = 8'd0; axi_arburst_i = 2'b01;
        for (int g = 0; g < 4; g++) begin
            axi_awvalid_i = 1'b1; axi_arvalid_i = 1'b1;
            n = 0;
            #1;
            while (!(axi_awready_o || axi_arready_o) && n < 100) begin @(negedge clk_i); #1; n++; end
            chk("arb_one_hot", {31'b0, axi_awready_o & axi_arready_o}, 32'd0);
            chk("arb_grant_read", {31'b0, axi_arready_o}, (g % 2 == 0) ? 32'd1 : 32'd0);
            if (axi_arready_o) begin
                @(posedge clk_i); @(negedge clk_i);
                axi_arvalid_i = 1'b0;
                r_phase(32'h10, 4'd2, 8'd0, 2'b01, 0, 1'b0);
            end else if (axi_awready_o) begin
                @(posedge clk_i); @(negedge clk_i);
                axi_awvalid_i = 1'b0;
                load_w(32'h5000 + 32'(g), 32'h0, 0, 4'hF);
                w_phase(32'h100, 4'd1, 8'd0, 2'b01);
            end
        end
        axi_awvalid_i = 1'b0; axi_arvalid_i = 1'b0;
        ar_phase(32'h100, 4'd3, 8'd0, 2'b01);
        r_phase(32'h100, 4'd3, 8'd0, 2'b01, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
